// File: rtl/secuenciador_ram_alu_pkg.sv
// -----------------------------------------------------------------------------
// secuenciador_ram_alu_pkg
//   Shared definitions for the RAM -> Banco -> ALU sequencer:
//   - default data/address/opcode widths
//   - FSM state encoding (4-bit, IDLE..FIN)
//   - ALU opcode constants understood by the external ALU
// -----------------------------------------------------------------------------
package secuenciador_ram_alu_pkg;

  localparam int ANCHO_DATO_DEF = 32;
  localparam int ANCHO_DIR_DEF  = 5;
  localparam int ANCHO_OP_DEF   = 3;

  // One state per cycle of the transfer; FIN is the single-cycle done state.
  typedef enum logic [3:0] {
    IDLE    = 4'd0,
    LEE_A   = 4'd1,
    ESC_A   = 4'd2,
    LEE_B   = 4'd3,
    ESC_B   = 4'd4,
    LEE_BR  = 4'd5,
    OPERA   = 4'd6,
    ESC_RES = 4'd7,
    FIN     = 4'd8
  } estado_t;

  localparam logic [2:0] OP_AND   = 3'b000;
  localparam logic [2:0] OP_SUMA  = 3'b010;
  localparam logic [2:0] OP_RESTA = 3'b110;

endpackage

// File: rtl/secuenciador_ram_alu_if.sv
// -----------------------------------------------------------------------------
// secuenciador_ram_alu_if
//   Bundles every non-clock signal of the sequencer:
//   - request:   inicio, DirA, DirB, DirRes, RegA, RegB, OpSel
//   - RAM:       DirRam, DatosE, WE (out) / DatosS (in, combinational read)
//   - Banco:     DL1, DL2, DE, Dato, WE_BR (out) / op1, op2 (in, combinational)
//   - ALU:       Ope1, Ope2, AluOp (out) / Resultado (in)
//   - status:    ocupado, listo, res_out
//   master = the sequencer, slave = the environment (RAM, Banco, ALU, requester).
// -----------------------------------------------------------------------------
interface secuenciador_ram_alu_if
  import secuenciador_ram_alu_pkg::*;
#(
  parameter int ANCHO_DATO = ANCHO_DATO_DEF,
  parameter int ANCHO_DIR  = ANCHO_DIR_DEF,
  parameter int ANCHO_OP   = ANCHO_OP_DEF
);

  // request
  logic                  inicio;
  logic [ANCHO_DIR-1:0]  DirA;
  logic [ANCHO_DIR-1:0]  DirB;
  logic [ANCHO_DIR-1:0]  DirRes;
  logic [ANCHO_DIR-1:0]  RegA;
  logic [ANCHO_DIR-1:0]  RegB;
  logic [ANCHO_OP-1:0]   OpSel;
  // RAM
  logic [ANCHO_DIR-1:0]  DirRam;
  logic [ANCHO_DATO-1:0] DatosE;
  logic                  WE;
  logic [ANCHO_DATO-1:0] DatosS;
  // Banco
  logic [ANCHO_DIR-1:0]  DL1;
  logic [ANCHO_DIR-1:0]  DL2;
  logic [ANCHO_DATO-1:0] op1;
  logic [ANCHO_DATO-1:0] op2;
  logic [ANCHO_DIR-1:0]  DE;
  logic [ANCHO_DATO-1:0] Dato;
  logic                  WE_BR;
  // ALU
  logic [ANCHO_DATO-1:0] Ope1;
  logic [ANCHO_DATO-1:0] Ope2;
  logic [ANCHO_OP-1:0]   AluOp;
  logic [ANCHO_DATO-1:0] Resultado;
  // status
  logic                  ocupado;
  logic                  listo;
  logic [ANCHO_DATO-1:0] res_out;

  modport master (
    input  inicio, DirA, DirB, DirRes, RegA, RegB, OpSel,
    input  DatosS, op1, op2, Resultado,
    output DirRam, DatosE, WE,
    output DL1, DL2, DE, Dato, WE_BR,
    output Ope1, Ope2, AluOp,
    output ocupado, listo, res_out
  );

  modport slave (
    output inicio, DirA, DirB, DirRes, RegA, RegB, OpSel,
    output DatosS, op1, op2, Resultado,
    input  DirRam, DatosE, WE,
    input  DL1, DL2, DE, Dato, WE_BR,
    input  Ope1, Ope2, AluOp,
    input  ocupado, listo, res_out
  );

endinterface

// File: rtl/secuenciador_ram_alu.sv
// -----------------------------------------------------------------------------
// secuenciador_ram_alu
//   On one inicio pulse (sampled in IDLE) reads operand A and B from RAM,
//   stores them in the register bank, reads both back, drives the ALU and
//   writes the result to RAM. One state per cycle:
//     IDLE -> LEE_A -> ESC_A -> LEE_B -> ESC_B -> LEE_BR -> OPERA -> ESC_RES -> FIN
//   Ports:
//     clk  - single clock, rising edge
//     rst  - synchronous, active-high reset
//     bus  - secuenciador_ram_alu_if.master (request, RAM, Banco, ALU, status)
//   All outputs are either registers or decoded from the state register.
// -----------------------------------------------------------------------------
module secuenciador_ram_alu
  import secuenciador_ram_alu_pkg::*;
#(
  parameter int ANCHO_DATO = ANCHO_DATO_DEF,
  parameter int ANCHO_DIR  = ANCHO_DIR_DEF,
  parameter int ANCHO_OP   = ANCHO_OP_DEF
) (
  input  logic                   clk,
  input  logic                   rst,
  secuenciador_ram_alu_if.master bus
);

  estado_t state_q, state_d;

  // request fields latched on acceptance; inputs are ignored afterwards
  logic [ANCHO_DIR-1:0]  dir_a_q,   dir_a_d;
  logic [ANCHO_DIR-1:0]  dir_b_q,   dir_b_d;
  logic [ANCHO_DIR-1:0]  dir_res_q, dir_res_d;
  logic [ANCHO_DIR-1:0]  reg_a_q,   reg_a_d;
  logic [ANCHO_DIR-1:0]  reg_b_q,   reg_b_d;
  logic [ANCHO_OP-1:0]   op_sel_q,  op_sel_d;

  // datapath registers
  logic [ANCHO_DATO-1:0] tmp_q,  tmp_d;
  logic [ANCHO_DATO-1:0] ope1_q, ope1_d;
  logic [ANCHO_DATO-1:0] ope2_q, ope2_d;
  logic [ANCHO_DATO-1:0] res_q,  res_d;

  // ---------------------------------------------------------------------------
  // next-state and register updates
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d   = state_q;
    dir_a_d   = dir_a_q;
    dir_b_d   = dir_b_q;
    dir_res_d = dir_res_q;
    reg_a_d   = reg_a_q;
    reg_b_d   = reg_b_q;
    op_sel_d  = op_sel_q;
    tmp_d     = tmp_q;
    ope1_d    = ope1_q;
    ope2_d    = ope2_q;
    res_d     = res_q;

    unique case (state_q)
      IDLE: begin
        if (bus.inicio) begin
          dir_a_d   = bus.DirA;
          dir_b_d   = bus.DirB;
          dir_res_d = bus.DirRes;
          reg_a_d   = bus.RegA;
          reg_b_d   = bus.RegB;
          op_sel_d  = bus.OpSel;
          state_d   = LEE_A;
        end
      end
      LEE_A: begin
        tmp_d   = bus.DatosS;
        state_d = ESC_A;
      end
      ESC_A:   state_d = LEE_B;
      LEE_B: begin
        tmp_d   = bus.DatosS;
        state_d = ESC_B;
      end
      ESC_B:   state_d = LEE_BR;
      LEE_BR: begin
        ope1_d  = bus.op1;
        ope2_d  = bus.op2;
        state_d = OPERA;
      end
      OPERA: begin
        res_d   = bus.Resultado;
        state_d = ESC_RES;
      end
      ESC_RES: state_d = FIN;
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      dir_a_q   <= '0;
      dir_b_q   <= '0;
      dir_res_q <= '0;
      reg_a_q   <= '0;
      reg_b_q   <= '0;
      op_sel_q  <= '0;
      tmp_q     <= '0;
      ope1_q    <= '0;
      ope2_q    <= '0;
      res_q     <= '0;
    end else begin
      state_q   <= state_d;
      dir_a_q   <= dir_a_d;
      dir_b_q   <= dir_b_d;
      dir_res_q <= dir_res_d;
      reg_a_q   <= reg_a_d;
      reg_b_q   <= reg_b_d;
      op_sel_q  <= op_sel_d;
      tmp_q     <= tmp_d;
      ope1_q    <= ope1_d;
      ope2_q    <= ope2_d;
      res_q     <= res_d;
    end
  end

  // ---------------------------------------------------------------------------
  // outputs decoded from the state register
  // ---------------------------------------------------------------------------
  always_comb begin
    bus.DirRam = '0;
    bus.DatosE = '0;
    bus.WE     = 1'b0;
    bus.DL1    = '0;
    bus.DL2    = '0;
    bus.DE     = '0;
    bus.Dato   = '0;
    bus.WE_BR  = 1'b0;

    unique case (state_q)
      LEE_A:   bus.DirRam = dir_a_q;
      LEE_B:   bus.DirRam = dir_b_q;
      ESC_A: begin
        bus.DE    = reg_a_q;
        bus.Dato  = tmp_q;
        bus.WE_BR = 1'b1;
      end
      ESC_B: begin
        bus.DE    = reg_b_q;
        bus.Dato  = tmp_q;
        bus.WE_BR = 1'b1;
      end
      LEE_BR: begin
        bus.DL1 = reg_a_q;
        bus.DL2 = reg_b_q;
      end
      ESC_RES: begin
        bus.DirRam = dir_res_q;
        bus.DatosE = res_q;
        bus.WE     = 1'b1;
      end
      default: ;
    endcase

    // A reset asserted in a write cycle must not let that write land on the
    // reset edge, so the enables are masked by rst.
    if (rst) begin
      bus.WE    = 1'b0;
      bus.WE_BR = 1'b0;
    end
  end

  assign bus.Ope1    = ope1_q;
  assign bus.Ope2    = ope2_q;
  assign bus.AluOp   = op_sel_q;
  assign bus.res_out = res_q;
  assign bus.ocupado = (state_q != IDLE);
  assign bus.listo   = (state_q == FIN);

endmodule
